// File: rtl/reg_file_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_pkg
//
// Shared definitions for the small register file: default geometry and
// the data/address types used by datapath code that talks to it.
// ---------------------------------------------------------------------------
package reg_file_pkg;

    localparam int DATA_WIDTH_DEF = 7;
    localparam int ADDR_WIDTH_DEF = 2;

    typedef logic [DATA_WIDTH_DEF-1:0] rf_data_t;
    typedef logic [ADDR_WIDTH_DEF-1:0] rf_addr_t;

endpackage : reg_file_pkg

// File: rtl/reg_file_entry.sv
// ---------------------------------------------------------------------------
// reg_file_entry
//
// One storage word of the register file.
// - Synchronous clear.
// - Load enable.
// - Clear has priority over load.
//
// Ports:
//   clk   input        rising-edge clock
//   rst   input        synchronous active-high clear
//   load  input        capture d on this edge
//   d     input  [W]   data to store
//   q     output [W]   stored value
// ---------------------------------------------------------------------------
module reg_file_entry
    import reg_file_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear wins over a simultaneous load, so a write on a reset edge is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule : reg_file_entry

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
//
// A 2**ADDR_WIDTH-entry register file. It has one synchronous write port and
// one combinational read port.
// The storage is built from discrete flip-flop entries rather than a RAM,
// because the read port is asynchronous.
// There is no write-to-read bypass. A read of the address being written
// shows the old value until the edge.
//
// Ports:
//   clk     input                 rising-edge clock
//   rst     input                 synchronous active-high reset, zeroes all
//   wr_en   input                 write enable
//   w_addr  input  [ADDR_WIDTH]   write address
//   w_data  input  [DATA_WIDTH]   write data
//   r_addr  input  [ADDR_WIDTH]   read address
//   r_data  output [DATA_WIDTH]   mem[r_addr], combinational
// ---------------------------------------------------------------------------
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic [ADDR_WIDTH-1:0] r_addr,
    output logic [DATA_WIDTH-1:0] r_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DEPTH-1:0]      entry_load;
    logic [DATA_WIDTH-1:0] entry_q [DEPTH];

    // One-hot write decode. At most one entry loads on a given edge.
    always_comb begin
        entry_load = '0;
        if (wr_en) begin
            entry_load[w_addr] = 1'b1;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        reg_file_entry #(
            .WIDTH (DATA_WIDTH)
        ) u_entry (
            .clk  (clk),
            .rst  (rst),
            .load (entry_load[i]),
            .d    (w_data),
            .q    (entry_q[i])
        );
    end

    // Every address is in range because the depth is a full power of two.
    assign r_data = entry_q[r_addr];

endmodule : reg_file

// File: tb/tb_reg_file.sv
// ---------------------------------------------------------------------------
// tb_reg_file
//
// Directed self-checking bench for reg_file. It uses the default geometry:
// 4 entries, 7 bits wide.
// ---------------------------------------------------------------------------
module tb_reg_file;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [1:0] w_addr;
    logic [6:0] w_data;
    logic [1:0] r_addr;
    logic [6:0] r_data;

    int checkCount;
    int errorCount;

    reg_file dut (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .w_addr (w_addr),
        .w_data (w_data),
        .r_addr (r_addr),
        .r_data (r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive every input at once with blocking assignments.
    task automatic applyStimulus(input logic s_rst, input logic s_wr_en,
                                 input logic [1:0] s_w_addr, input logic [6:0] s_w_data,
                                 input logic [1:0] s_r_addr);
        rst    = s_rst;
        wr_en  = s_wr_en;
        w_addr = s_w_addr;
        w_data = s_w_data;
        r_addr = s_r_addr;
    endtask

    // Advance one rising edge, then step off the edge before anything changes.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let the combinational read settle, then compare against the expected value.
    task automatic checkOutput(input string tag, input logic [6:0] expected);
        #1;
        checkCount++;
        assert (r_data === expected)
        else begin
            errorCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, r_data, expected);
        end
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;

        // Reset held for two edges, then every address reads zero.
        applyStimulus(1'b1, 1'b0, 2'd0, 7'd0, 2'd0);
        tick();
        tick();
        applyStimulus(1'b0, 1'b0, 2'd0, 7'd0, 2'd0);
        checkOutput("reset_addr0", 7'd0);
        r_addr = 2'd1;
        checkOutput("reset_addr1", 7'd0);
        r_addr = 2'd2;
        checkOutput("reset_addr2", 7'd0);
        r_addr = 2'd3;
        checkOutput("reset_addr3", 7'd0);

        // Sequential writes, each held for two edges.
        // The first write is read back right after its first edge.
        applyStimulus(1'b0, 1'b1, 2'd0, 7'd100, 2'd0);
        tick();
        checkOutput("write_latency_addr0", 7'd100);
        tick();
        applyStimulus(1'b0, 1'b1, 2'd1, 7'd101, 2'd0);
        tick();
        tick();
        applyStimulus(1'b0, 1'b1, 2'd2, 7'd110, 2'd0);
        tick();
        tick();
        applyStimulus(1'b0, 1'b0, 2'd0, 7'd0, 2'd0);
        checkOutput("seq_addr0", 7'd100);
        r_addr = 2'd1;
        checkOutput("seq_addr1", 7'd101);
        r_addr = 2'd2;
        checkOutput("seq_addr2", 7'd110);

        // With the write disabled, addr3 keeps its reset value.
        applyStimulus(1'b0, 1'b0, 2'd3, 7'd120, 2'd3);
        tick();
        tick();
        checkOutput("wr_dis_addr3", 7'd0);
        r_addr = 2'd0;
        checkOutput("wr_dis_addr0", 7'd100);
        r_addr = 2'd1;
        checkOutput("wr_dis_addr1", 7'd101);
        r_addr = 2'd2;
        checkOutput("wr_dis_addr2", 7'd110);

        // Combinational read: r_data follows r_addr with no clock edge.
        r_addr = 2'd1;
        checkOutput("comb_read_addr1", 7'd101);

        // Same-address read/write: old value before the edge, new value after.
        applyStimulus(1'b0, 1'b1, 2'd0, 7'd55, 2'd0);
        checkOutput("rw_same_before", 7'd100);
        tick();
        checkOutput("rw_same_after", 7'd55);
        wr_en  = 1'b0;
        r_addr = 2'd1;
        checkOutput("rw_same_neighbor", 7'd101);

        // Full-scale value written to the top address.
        applyStimulus(1'b0, 1'b1, 2'd3, 7'd127, 2'd3);
        tick();
        wr_en = 1'b0;
        checkOutput("max_value_addr3", 7'd127);

        // Reset priority: the write on the reset edge is dropped.
        applyStimulus(1'b1, 1'b1, 2'd1, 7'd127, 2'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 2'd0, 7'd0, 2'd1);
        checkOutput("rst_prio_addr1", 7'd0);
        r_addr = 2'd0;
        checkOutput("rst_prio_addr0", 7'd0);
        r_addr = 2'd2;
        checkOutput("rst_prio_addr2", 7'd0);
        r_addr = 2'd3;
        checkOutput("rst_prio_addr3", 7'd0);

        // Writes resume on the first edge after reset is released.
        applyStimulus(1'b0, 1'b1, 2'd2, 7'd42, 2'd2);
        tick();
        wr_en = 1'b0;
        checkOutput("resume_addr2", 7'd42);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule : tb_reg_file
